// File: rtl/controle_envase.sv
// controle_envase: bottling line sequencer (conveyor, filler, capper, dozen count, box change)
// Parameters: TEMPO_VEDACAO capper hold cycles, TEMPO_ENCHER_MAX fill timeout cycles.
// Inputs:  CLOCK, RESET (sync, active high), START, STOP, SENSOR_GARRAFA, NIVEL_OK,
//          CAIXA_PRONTA, ACK_ERRO.
// Outputs: MOTOR, VALVULA, VEDADOR, CONTA_EN, TROCA_CAIXA, ERRO, COD_ERRO[1:0],
//          GARRAFAS[3:0], ESTADO[2:0].
// Macro CONTROLE_TIMEOUT_EN enables the fill timeout fault (COD_ERRO=1).
module controle_envase #(
    parameter int TEMPO_VEDACAO    = 8,
    parameter int TEMPO_ENCHER_MAX = 200
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    input  logic       SENSOR_GARRAFA,
    input  logic       NIVEL_OK,
    input  logic       CAIXA_PRONTA,
    input  logic       ACK_ERRO,
    output logic       MOTOR,
    output logic       VALVULA,
    output logic       VEDADOR,
    output logic       CONTA_EN,
    output logic       TROCA_CAIXA,
    output logic       ERRO,
    output logic [1:0] COD_ERRO,
    output logic [3:0] GARRAFAS,
    output logic [2:0] ESTADO
);
    typedef enum logic [2:0] {
        PARADO, ESTEIRA, ENCHENDO, VEDANDO, CONTANDO, SAIDA, TROCA, FALHA
    } estado_t;
`ifdef CONTROLE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [7:0] FIM_VED = 8'(TEMPO_VEDACAO - 1);
    localparam logic [7:0] FIM_ENC = 8'(TEMPO_ENCHER_MAX - 1);
    estado_t estado, prox;
    logic [7:0] timer;
    logic stop_pend;
    logic [1:0] cod_prox;
    always_comb begin
        prox = estado;
        cod_prox = COD_ERRO;
        case (estado)
            PARADO:   if (START && !STOP) prox = ESTEIRA;
            ESTEIRA:  prox = STOP ? PARADO : SENSOR_GARRAFA ? ENCHENDO : ESTEIRA;
            ENCHENDO: begin
                if (!SENSOR_GARRAFA) begin
                    prox = FALHA;
                    cod_prox = 2'd2;
                end else if (TIMEOUT_EN && timer == FIM_ENC && !NIVEL_OK) begin
                    prox = FALHA;
                    cod_prox = 2'd1;
                end else if (STOP) prox = PARADO;
                else if (NIVEL_OK) prox = VEDANDO;
            end
            VEDANDO: begin
                if (!SENSOR_GARRAFA) begin
                    prox = FALHA;
                    cod_prox = 2'd2;
                end else if (STOP) prox = PARADO;
                else if (timer == FIM_VED) prox = CONTANDO;
            end
            CONTANDO: prox = (GARRAFAS == 4'd11) ? TROCA : SAIDA;
            TROCA:    if (CAIXA_PRONTA) prox = SAIDA;
            // the counted bottle must clear the sensor before any stop takes effect
            SAIDA:    if (!SENSOR_GARRAFA) prox = (stop_pend || STOP) ? PARADO : ESTEIRA;
            FALHA: begin
                if (ACK_ERRO) begin
                    prox = PARADO;
                    cod_prox = 2'd0;
                end
            end
            default:  prox = PARADO;
        endcase
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            estado    <= PARADO;
            timer     <= '0;
            stop_pend <= 1'b0;
            COD_ERRO  <= 2'd0;
            GARRAFAS  <= 4'd0;
        end else begin
            estado    <= prox;
            COD_ERRO  <= cod_prox;
            timer     <= (prox != estado) ? 8'd0 : timer + 8'd1;
            stop_pend <= (prox == PARADO) ? 1'b0
                       : (STOP && estado inside {CONTANDO, SAIDA, TROCA}) ? 1'b1 : stop_pend;
            if (estado == CONTANDO) GARRAFAS <= (GARRAFAS == 4'd11) ? 4'd0 : GARRAFAS + 4'd1;
        end
    end
    assign MOTOR       = estado inside {ESTEIRA, SAIDA};
    assign VALVULA     = estado == ENCHENDO;
    assign VEDADOR     = estado == VEDANDO;
    assign CONTA_EN    = estado == CONTANDO;
    assign TROCA_CAIXA = estado == TROCA;
    assign ERRO        = estado == FALHA;
    assign ESTADO      = estado;
endmodule

// File: tb/tb_controle_envase.sv
// tb_controle_envase: directed self-checking bench for controle_envase
module tb_controle_envase;
    logic clk = 1'b0;
    logic rst, start, stop, sensor, nivel, caixa, ack;
    logic motor, valvula, vedador, conta_en, troca_caixa, erro;
    logic [1:0] cod_erro;
    logic [3:0] garrafas;
    logic [2:0] estado;
    int tests = 0;
    int fails = 0;

    controle_envase dut (
        .CLOCK(clk), .RESET(rst), .START(start), .STOP(stop),
        .SENSOR_GARRAFA(sensor), .NIVEL_OK(nivel), .CAIXA_PRONTA(caixa), .ACK_ERRO(ack),
        .MOTOR(motor), .VALVULA(valvula), .VEDADOR(vedador), .CONTA_EN(conta_en),
        .TROCA_CAIXA(troca_caixa), .ERRO(erro), .COD_ERRO(cod_erro),
        .GARRAFAS(garrafas), .ESTADO(estado)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nome, input int obs, input int esp);
        tests++;
        if (obs !== esp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nome, obs, esp);
        end
    endtask

    // from ESTEIRA with bottle arriving, drives one bottle up to CONTANDO
    task automatic run_bottle(output int pulsos);
        pulsos = 0;
        sensor = 1'b1;
        tick();
        nivel = 1'b1;
        tick();
        nivel = 1'b0;
        repeat (8) begin
            tick();
            pulsos += int'(conta_en);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; sensor = 1'b0;
        nivel = 1'b0; caixa = 1'b0; ack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_estado", estado, 0);
        chk("reset_saidas", {motor, valvula, vedador, conta_en, troca_caixa, erro}, 0);
        chk("reset_garrafas", garrafas, 0);
        chk("reset_cod", cod_erro, 0);
        tick();
        chk("parado_sem_start", estado, 0);
    endtask

    task automatic test_one_bottle();
        int ved = 0;
        start = 1'b1;
        tick();
        chk("start_esteira", estado, 1);
        chk("esteira_motor", motor, 1);
        sensor = 1'b1;
        tick();
        chk("enchendo", estado, 2);
        chk("valvula", valvula, 1);
        tick();
        tick();
        chk("enchendo_espera", estado, 2);
        nivel = 1'b1;
        tick();
        nivel = 1'b0;
        for (int i = 0; i < 20 && vedador; i++) begin
            ved++;
            tick();
        end
        chk("vedador_ciclos", ved, 8);
        chk("contando", estado, 4);
        chk("conta_en", conta_en, 1);
        chk("garrafas_antes", garrafas, 0);
        tick();
        chk("saida", estado, 5);
        chk("conta_en_um_ciclo", conta_en, 0);
        chk("garrafas_1", garrafas, 1);
        chk("saida_motor", motor, 1);
        tick();
        chk("saida_espera_sensor", estado, 5);
        sensor = 1'b0;
        tick();
        chk("volta_esteira", estado, 1);
    endtask

    task automatic test_dozen();
        int p, total = 0;
        do_reset();
        start = 1'b1;
        tick();
        for (int b = 0; b < 12; b++) begin
            run_bottle(p);
            total += p;
            if (b == 11) chk("garrafas_11", garrafas, 11);
            tick();
            if (b < 11) begin
                sensor = 1'b0;
                tick();
            end
        end
        chk("dozen_pulsos", total, 12);
        chk("troca", estado, 6);
        chk("troca_caixa", troca_caixa, 1);
        chk("garrafas_wrap", garrafas, 0);
        repeat (3) tick();
        chk("troca_segura", estado, 6);
        caixa = 1'b1;
        tick();
        caixa = 1'b0;
        chk("troca_saida", estado, 5);
        sensor = 1'b0;
        tick();
        chk("troca_esteira", estado, 1);
    endtask

    task automatic test_stop_contando();
        int p;
        run_bottle(p);
        chk("stop_em_contando", estado, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_saida", estado, 5);
        tick();
        chk("stop_pendente_saida", estado, 5);
        sensor = 1'b0;
        tick();
        chk("stop_parado", estado, 0);
        chk("stop_garrafas", garrafas, 1);
        start = 1'b0;
        tick();
        chk("stop_fica_parado", estado, 0);
    endtask

    task automatic test_stop_vedando();
        start = 1'b1;
        tick();
        start = 1'b0;
        sensor = 1'b1;
        tick();
        nivel = 1'b1;
        tick();
        nivel = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_vedando_parado", estado, 0);
        start = 1'b1;
        tick();
        tick();
        chk("retoma_enchendo", estado, 2);
        chk("retoma_garrafas", garrafas, 1);
    endtask

    task automatic test_fault();
        nivel = 1'b1;
        tick();
        nivel = 1'b0;
        chk("fault_vedando", estado, 3);
        tick();
        tick();
        sensor = 1'b0;
        tick();
        chk("fault_estado", estado, 7);
        chk("fault_erro", erro, 1);
        chk("fault_cod", cod_erro, 2);
        chk("fault_motor", motor, 0);
        tick();
        chk("fault_segura", estado, 7);
        start = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_parado", estado, 0);
        chk("ack_cod", cod_erro, 0);
        chk("ack_garrafas", garrafas, 1);
    endtask

    task automatic test_fill_wait();
        start = 1'b1;
        tick();
        sensor = 1'b1;
        tick();
        repeat (250) tick();
`ifdef CONTROLE_TIMEOUT_EN
        chk("timeout_estado", estado, 7);
        chk("timeout_cod", cod_erro, 1);
`else
        chk("sem_timeout_estado", estado, 2);
        chk("sem_timeout_cod", cod_erro, 0);
`endif
    endtask

    task automatic test_reset_troca();
        int p;
        do_reset();
        start = 1'b1;
        tick();
        for (int b = 0; b < 12; b++) begin
            run_bottle(p);
            tick();
            if (b < 11) begin
                sensor = 1'b0;
                tick();
            end
        end
        chk("rt_troca", estado, 6);
        chk("rt_garrafas", garrafas, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rt_parado", estado, 0);
        chk("rt_saidas", {motor, valvula, vedador, conta_en, troca_caixa, erro, cod_erro}, 0);
    endtask

    initial begin
        test_reset();
        test_one_bottle();
        test_dozen();
        test_stop_contando();
        test_stop_vedando();
        test_fault();
        test_fill_wait();
        test_reset_troca();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
